// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : Round-robin arbiter sharing one fixed-latency single-port SRAM,
//            with a bounded lock for atomic sequences and 1-cycle rvalid routing.
// Revision : 1.0
// ============================================================================
module mem_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 64,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_LOCK_CYCLES = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]    be_i,
    input  logic [NUM_REQ-1:0]             lock_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [BE_WIDTH-1:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_cnd_w = c_idx_w + 1;
    localparam int c_cnt_w = $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_LOCK_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t          r_state;
    lock_state_t          w_state_nxt;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_owner_idx;
    logic [c_idx_w-1:0]   w_owner_nxt;
    logic [c_cnt_w-1:0]   r_lock_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_lock_blk;
    logic [NUM_REQ-1:0]   w_blk_nxt;
    logic                 r_resp_vld;
    logic [c_idx_w-1:0]   r_resp_idx;
    logic                 w_win_vld;
    logic [c_idx_w-1:0]   w_win_idx;
    logic [c_cnd_w-1:0]   w_cand;
    logic                 w_grant;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
    logic [BE_WIDTH-1:0]   w_be_arr    [NUM_REQ];

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_req
            assign w_addr_arr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_be_arr[k]    = be_i[k*BE_WIDTH +: BE_WIDTH];
            assign gnt_o[k]       = w_grant && (w_win_idx == c_idx_w'(k));
            assign rvalid_o[k]    = r_resp_vld && !rst_i && (r_resp_idx == c_idx_w'(k));
        end
    endgenerate

    // Winner selection: owner only while locked, else first requester from r_rr_ptr.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        if (r_state == ST_LOCKED) begin
            w_win_vld = req_i[r_owner_idx];
            w_win_idx = r_owner_idx;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand = {1'b0, r_rr_ptr} + c_cnd_w'(i);
                if (w_cand >= c_cnd_w'(NUM_REQ)) begin
                    w_cand = w_cand - c_cnd_w'(NUM_REQ);
                end
                if (!w_win_vld && req_i[w_cand[c_idx_w-1:0]]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = w_cand[c_idx_w-1:0];
                end
            end
        end
    end

    assign w_grant     = w_win_vld && !rst_i;
    assign mem_req_o   = w_grant;
    assign mem_we_o    = we_i[w_win_idx];
    assign mem_addr_o  = w_addr_arr[w_win_idx];
    assign mem_wdata_o = w_wdata_arr[w_win_idx];
    assign mem_be_o    = w_be_arr[w_win_idx];
    assign rdata_o     = mem_rdata_i;

    // Lock tracking; a lock released by the owner never marks it blocked.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner_idx;
        w_cnt_nxt   = r_lock_cnt;
        w_blk_nxt   = r_lock_blk & lock_i;
        case (r_state)
            ST_IDLE: begin
                if (w_grant && lock_i[w_win_idx] && !r_lock_blk[w_win_idx]) begin
                    w_owner_nxt = w_win_idx;
                    w_cnt_nxt   = c_cnt_one;
                    if (c_cnt_one == c_cnt_max) begin
                        w_blk_nxt[w_win_idx] = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (!lock_i[r_owner_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_lock_cnt + c_cnt_one;
                    if (w_cnt_nxt == c_cnt_max) begin
                        w_state_nxt            = ST_IDLE;
                        w_blk_nxt[r_owner_idx] = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_owner_idx <= '0;
            r_lock_cnt  <= '0;
            r_lock_blk  <= '0;
            r_rr_ptr    <= '0;
            r_resp_vld  <= 1'b0;
            r_resp_idx  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_idx <= w_owner_nxt;
            r_lock_cnt  <= w_cnt_nxt;
            r_lock_blk  <= w_blk_nxt;
            if (w_grant) begin
                r_rr_ptr <= (w_win_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
            end
            r_resp_vld  <= w_grant;
            r_resp_idx  <= w_win_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Purpose  : Directed and randomized checks of mem_rr_arbiter against a
//            behavioural arbitration/lock/memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 20;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;
    localparam int MAXL = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [BW-1:0]   mem_be;
    logic [DW-1:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_LOCK_CYCLES(MAXL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .be_i(be), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // SRAM macro stand-in: one-cycle read latency, byte-enabled writes.
    bit [DW-1:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) sram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    // Reference model state
    bit [DW-1:0] ref_mem [0:255];
    int          m_ptr, m_owner, m_cnt, m_resp_idx;
    bit          m_locked, m_resp_vld, m_resp_rd;
    bit [N-1:0]  m_blk;
    logic [DW-1:0] m_resp_data;

    int            exp_win;
    logic [N-1:0]  exp_gnt, exp_rvalid;
    bit            exp_rd;
    logic [DW-1:0] exp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset;
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_resp_idx = 0;
        m_locked = 0; m_resp_vld = 0; m_resp_rd = 0; m_blk = '0;
    endtask

    task automatic predict;
        #1;
        if (rst) model_reset();
        exp_win = -1;
        if (!rst) begin
            if (m_locked) begin
                if (req[m_owner]) exp_win = m_owner;
            end else begin
                for (int i = 0; i < N; i++)
                    if (exp_win < 0 && req[(m_ptr + i) % N]) exp_win = (m_ptr + i) % N;
            end
        end
        exp_gnt = '0;
        if (exp_win >= 0) exp_gnt[exp_win] = 1'b1;
        exp_rvalid = '0;
        if (m_resp_vld) exp_rvalid[m_resp_idx] = 1'b1;
        exp_rd    = m_resp_vld && m_resp_rd;
        exp_rdata = m_resp_data;
    endtask

    task automatic advance;
        int a;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < N; k++) if (!lock[k]) m_blk[k] = 1'b0;
            if (m_locked) begin
                if (!lock[m_owner]) begin
                    m_locked = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == MAXL) begin
                        m_locked = 0;
                        m_blk[m_owner] = 1'b1;
                    end
                end
            end else if (exp_win >= 0 && lock[exp_win] && !m_blk[exp_win]) begin
                m_owner = exp_win; m_cnt = 1; m_locked = 1;
            end
            m_resp_vld = (exp_win >= 0);
            if (exp_win >= 0) begin
                m_ptr       = (exp_win + 1) % N;
                m_resp_idx  = exp_win;
                m_resp_rd   = !we[exp_win];
                a           = int'(addr[exp_win*AW +: 8]);
                m_resp_data = ref_mem[a];
                if (we[exp_win])
                    for (int b = 0; b < BW; b++)
                        if (be[exp_win*BW + b]) ref_mem[a][b*8 +: 8] = wdata[exp_win*DW + b*8 +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_all;
        req = '0; we = '0; lock = '0;
    endtask

    task automatic set_req(input int k, input logic w, input logic l, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
        req[k] = 1'b1; we[k] = w; lock[k] = l;
        addr[k*AW +: AW] = a; wdata[k*DW +: DW] = d; be[k*BW +: BW] = b;
    endtask

    task automatic pulse_reset;
        rst = 1'b1; clear_all();
        predict(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '1; lock = '1; we = '0;
        predict();
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else n_pass++;
        n_checks++; if (rvalid !== 4'b0000) $display("FAIL reset_rvalid: got %b expected 0000", rvalid); else n_pass++;
        advance();
        rst = 1'b0; clear_all();
        predict();
        n_checks++; if (rvalid !== 4'b0000) $display("FAIL post_reset_rvalid: got %b expected 0000", rvalid); else n_pass++;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL post_reset_gnt_idle: got %b expected 0000", gnt); else n_pass++;
        advance();
    endtask

    task automatic test_write_read;
        clear_all();
        set_req(0, 1'b1, 1'b0, 20'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        predict();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL wr_gnt: got %b expected 0001", gnt); else n_pass++;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'h10) $display("FAIL wr_mem_cmd: got we=%b addr=%h expected we=1 addr=00010", mem_we, mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 64'hDEAD_BEEF_0123_4567 || mem_be !== 8'hFF) $display("FAIL wr_mem_data: got %h/%h expected deadbeef01234567/ff", mem_wdata, mem_be); else n_pass++;
        advance();
        set_req(0, 1'b0, 1'b0, 20'h10, 64'h0, 8'h00);
        predict();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL rd_gnt: got %b expected 0001", gnt); else n_pass++;
        n_checks++; if (rvalid !== 4'b0001) $display("FAIL wr_rvalid: got %b expected 0001", rvalid); else n_pass++;
        advance();
        clear_all();
        predict();
        n_checks++; if (rvalid !== 4'b0001) $display("FAIL rd_rvalid: got %b expected 0001", rvalid); else n_pass++;
        n_checks++; if (rdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL rd_data: got %h expected deadbeef01234567", rdata); else n_pass++;
        advance();
    endtask

    task automatic test_round_robin;
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        logic [N-1:0] e;
        pulse_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, AW'(k), 64'h0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            predict();
            e = 4'b0001 << seq[i];
            n_checks++; if (gnt !== e) $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, e); else n_pass++;
            e = (i == 0) ? 4'b0000 : (4'b0001 << seq[i-1]);
            n_checks++; if (rvalid !== e) $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, e); else n_pass++;
            advance();
        end
        clear_all();
    endtask

    task automatic test_lock_pending;
        pulse_reset();
        set_req(0, 1'b0, 1'b0, 20'h1, 64'h0, 8'h00);
        predict();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL lkp_pre_gnt: got %b expected 0001", gnt); else n_pass++;
        advance();
        set_req(1, 1'b1, 1'b1, 20'h2, 64'h1111, 8'hFF);
        set_req(2, 1'b0, 1'b0, 20'h3, 64'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) lock[1] = 1'b0;
            predict();
            n_checks++; if (gnt !== 4'b0010) $display("FAIL lkp_owner_gnt[%0d]: got %b expected 0010", i, gnt); else n_pass++;
            n_checks++; if (rvalid !== exp_rvalid) $display("FAIL lkp_rvalid[%0d]: got %b expected %b", i, rvalid, exp_rvalid); else n_pass++;
            advance();
        end
        req[1] = 1'b0;
        predict();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL lkp_after_gnt2: got %b expected 0100", gnt); else n_pass++;
        advance();
        req[2] = 1'b0;
        predict();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL lkp_after_gnt0: got %b expected 0001", gnt); else n_pass++;
        advance();
        clear_all();
    endtask

    task automatic test_lock_timeout;
        int rot [3] = '{3, 0, 1};
        int w;
        logic [N-1:0] e;
        pulse_reset();
        set_req(0, 1'b0, 1'b0, 20'h4, 64'h0, 8'h00);
        predict(); advance();
        set_req(1, 1'b0, 1'b1, 20'h5, 64'h0, 8'h00);
        set_req(3, 1'b0, 1'b0, 20'h6, 64'h0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            predict();
            w = (i < MAXL) ? 1 : rot[(i - MAXL) % 3];
            e = 4'b0001 << w;
            n_checks++; if (gnt !== e) $display("FAIL lkto_gnt[%0d]: got %b expected %b", i, gnt, e); else n_pass++;
            advance();
        end
        lock[1] = 1'b0;
        predict();
        n_checks++; if (gnt !== 4'b1000) $display("FAIL lkto_release_gnt: got %b expected 1000", gnt); else n_pass++;
        advance();
        clear_all();
    endtask

    task automatic test_partial_write;
        clear_all();
        set_req(0, 1'b1, 1'b0, 20'h20, 64'h0, 8'hFF);
        predict(); advance();
        set_req(0, 1'b1, 1'b0, 20'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        predict(); advance();
        set_req(0, 1'b0, 1'b0, 20'h20, 64'h0, 8'h00);
        predict(); advance();
        clear_all();
        predict();
        n_checks++; if (rvalid !== 4'b0001) $display("FAIL pw_rvalid: got %b expected 0001", rvalid); else n_pass++;
        n_checks++; if (rdata !== 64'h0000_0000_FFFF_FFFF) $display("FAIL pw_rdata: got %h expected 00000000ffffffff", rdata); else n_pass++;
        advance();
    endtask

    task automatic test_reset_mid;
        pulse_reset();
        set_req(2, 1'b0, 1'b1, 20'h7, 64'h0, 8'h00);
        predict();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL rm_lock_gnt: got %b expected 0100", gnt); else n_pass++;
        advance();
        rst = 1'b1;
        predict();
        n_checks++; if (rvalid !== 4'b0000) $display("FAIL rm_rvalid_dropped: got %b expected 0000", rvalid); else n_pass++;
        n_checks++; if (gnt !== 4'b0000 || mem_req !== 1'b0) $display("FAIL rm_gnt_in_reset: got %b/%b expected 0000/0", gnt, mem_req); else n_pass++;
        advance();
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, (k == 2), AW'(k), 64'h0, 8'h00);
        predict();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL rm_first_gnt: got %b expected 0001", gnt); else n_pass++;
        advance();
        req[0] = 1'b0;
        predict();
        n_checks++; if (gnt !== 4'b0010) $display("FAIL rm_no_lock_gnt: got %b expected 0010", gnt); else n_pass++;
        n_checks++; if (rvalid !== 4'b0001) $display("FAIL rm_rvalid_after: got %b expected 0001", rvalid); else n_pass++;
        advance();
        clear_all();
    endtask

    task automatic test_random;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) begin
                req[k] = ($urandom_range(0, 3) != 0);
                we[k]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) lock[k] = ~lock[k];
                addr[k*AW +: AW]  = AW'($urandom_range(0, 15));
                wdata[k*DW +: DW] = {$urandom, $urandom};
                be[k*BW +: BW]    = BW'($urandom);
            end
            predict();
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, exp_gnt); else n_pass++;
            n_checks++; if (mem_req !== (|exp_gnt)) $display("FAIL rnd_mem_req[%0d]: got %b expected %b", c, mem_req, |exp_gnt); else n_pass++;
            n_checks++; if (rvalid !== exp_rvalid) $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, rvalid, exp_rvalid); else n_pass++;
            if (exp_win >= 0) begin
                n_checks++;
                if (mem_we !== we[exp_win] || mem_addr !== addr[exp_win*AW +: AW] ||
                    mem_wdata !== wdata[exp_win*DW +: DW] || mem_be !== be[exp_win*BW +: BW])
                    $display("FAIL rnd_mem_mux[%0d]: got we=%b addr=%h be=%h expected requester %0d fields", c, mem_we, mem_addr, mem_be, exp_win);
                else n_pass++;
            end
            if (exp_rd) begin
                n_checks++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, rdata, exp_rdata); else n_pass++;
            end
            advance();
        end
        rst = 1'b0;
        clear_all();
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        addr = '0; wdata = '0; be = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_pending();
        test_lock_timeout();
        test_partial_write();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
